bcd_score_counter: RTL and testbench

- Parametrised multi-digit BCD score register for the game datapath; replaces per-digit hand-chained counters with one DIGITS-wide block.
- Applies a single ±1/±2 command per cycle and ripples carry/borrow internally across all digits.
- Clamps at 0 and at all-nines.
- Drives the 7-segment score display path through SCORE.

---
 rtl/bcd_pkg.sv | 6 +
 rtl/bcd_score_counter_if.sv | 12 +
 rtl/bcd_digit_step.sv | 22 ++
 rtl/bcd_score_counter.sv | 88 ++++++++
 tb/tb_bcd_score_counter.sv | 125 ++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, constants and command encoding (also used by the display decoder)
package bcd_pkg;
  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_NINE = 4'd9;
  typedef enum logic [2:0] {CMD_NONE, CMD_UP1, CMD_UP2, CMD_DN2, CMD_DN1} cmd_e;
endpackage

// File: rtl/bcd_score_counter_if.sv
// bcd_score_counter_if: command inputs and score/flag outputs of the score counter
// master: drives CLEAR/UP1/UP2/DOWN2/DOWN1, observes SCORE/ZERO/OVERFLOW/UNDERFLOW/COMBO
// slave:  the counter side of the same signals
interface bcd_score_counter_if #(parameter int DIGITS = 4);
  logic CLEAR, UP1, UP2, DOWN2, DOWN1;
  logic [4*DIGITS-1:0] SCORE;
  logic ZERO, OVERFLOW, UNDERFLOW, COMBO;
  modport master(output CLEAR, UP1, UP2, DOWN2, DOWN1,
                 input SCORE, ZERO, OVERFLOW, UNDERFLOW, COMBO);
  modport slave(input CLEAR, UP1, UP2, DOWN2, DOWN1,
                output SCORE, ZERO, OVERFLOW, UNDERFLOW, COMBO);
endinterface

// File: rtl/bcd_digit_step.sv
// bcd_digit_step: one BCD digit add/subtract of 0..4 with carry/borrow out
// a_i: current digit, d_i: amount (delta on digit 0, carry/borrow on the rest)
// sub_i: subtract instead of add, q_o: result digit, c_o: carry (add) or borrow (sub)
module bcd_digit_step
  import bcd_pkg::*;
(
  input  bcd_t       a_i,
  input  logic [2:0] d_i,
  input  logic       sub_i,
  output bcd_t       q_o,
  output logic       c_o
);
  logic [4:0] sum, dif, sum_adj;
  logic       hi;
  assign sum     = {1'b0, a_i} + {2'b0, d_i};
  assign dif     = {1'b0, a_i} - {2'b0, d_i};
  assign sum_adj = sum - 5'd10;
  assign hi      = sum > 5'd9;
  assign c_o     = sub_i ? dif[4] : hi;
  // a negative difference wraps mod 16, adding 10 mod 16 lands on the right digit
  assign q_o     = sub_i ? (dif[4] ? dif[3:0] + 4'd10 : dif[3:0]) : (hi ? sum_adj[3:0] : sum[3:0]);
endmodule

// File: rtl/bcd_score_counter.sv
// bcd_score_counter: DIGITS-wide BCD score register with +-1/+-2 commands and clamping
// CLOCK/RESET: clock and synchronous active-high reset
// bus (slave): CLEAR/UP1/UP2/DOWN2/DOWN1 in; SCORE/ZERO/OVERFLOW/UNDERFLOW/COMBO out
// BCD_SCORE_COMBO_EN: enables the up-streak counter that doubles up-deltas while COMBO=1
module bcd_score_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int COMBO_LEN = 4
) (
  input logic CLOCK,
  input logic RESET,
  bcd_score_counter_if.slave bus
);
  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] NINES = {DIGITS{BCD_NINE}};
  cmd_e            cmd;
  logic            up, dn, combo, ov_d, un_d;
  logic [2:0]      mag, delta;
  logic [W-1:0]    score_q, score_d, sum;
  logic [DIGITS-1:0] c;
  logic            zero_q, ov_q, un_q;
  always_comb begin
    cmd   = bus.UP2 ? CMD_UP2 : bus.UP1 ? CMD_UP1 : bus.DOWN2 ? CMD_DN2 : bus.DOWN1 ? CMD_DN1 : CMD_NONE;
    up    = !bus.CLEAR && (cmd == CMD_UP1 || cmd == CMD_UP2);
    dn    = !bus.CLEAR && (cmd == CMD_DN1 || cmd == CMD_DN2);
    mag   = (cmd == CMD_UP2 || cmd == CMD_DN2) ? 3'd2 : 3'd1;
    delta = (combo && up) ? mag << 1 : mag;
  end
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    logic [2:0] d_in;
    if (g == 0) begin : g_lsd
      assign d_in = delta;
    end else begin : g_rip
      assign d_in = {2'b0, c[g-1]};
    end
    bcd_digit_step u_step (
      .a_i  (score_q[4*g+:4]),
      .d_i  (d_in),
      .sub_i(dn),
      .q_o  (sum[4*g+:4]),
      .c_o  (c[g])
    );
  end
  // a carry/borrow out of the top digit means the true result left 0..10^DIGITS-1
  always_comb begin
    ov_d    = up && c[DIGITS-1];
    un_d    = dn && c[DIGITS-1];
    score_d = bus.CLEAR ? '0 : ov_d ? NINES : un_d ? '0 : (up || dn) ? sum : score_q;
  end
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      score_q <= '0;
      zero_q  <= 1'b1;
      ov_q    <= 1'b0;
      un_q    <= 1'b0;
    end else begin
      score_q <= score_d;
      zero_q  <= score_d == '0;
      ov_q    <= ov_d;
      un_q    <= un_d;
    end
  end
`ifdef BCD_SCORE_COMBO_EN
  logic [3:0] streak_q, streak_d;
  logic       combo_q;
  always_comb streak_d = (bus.CLEAR || dn) ? 4'd0 : up ? (streak_q == 4'd15 ? 4'd15 : streak_q + 4'd1) : streak_q;
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      streak_q <= 4'd0;
      combo_q  <= 1'b0;
    end else begin
      streak_q <= streak_d;
      combo_q  <= streak_d >= 4'(COMBO_LEN);
    end
  end
  assign combo = combo_q;
`else
  logic unused_combo_len;
  assign unused_combo_len = COMBO_LEN > 0;
  assign combo            = 1'b0;
`endif
  assign bus.SCORE     = score_q;
  assign bus.ZERO      = zero_q;
  assign bus.OVERFLOW  = ov_q;
  assign bus.UNDERFLOW = un_q;
  assign bus.COMBO     = combo;
endmodule

// File: tb/tb_bcd_score_counter.sv
// tb_bcd_score_counter: scoreboard bench for bcd_score_counter (DIGITS=3, COMBO_LEN=2)
module tb_bcd_score_counter;
  localparam int DIGITS = 3;
  localparam int MAXV   = 999;
  localparam int CLEN   = 2;
  typedef struct {
    int score;
    bit zero, ov, un, combo;
  } exp_t;
  logic clk, rst;
  int   checks, failures;
  int   m_score, m_streak;
  exp_t q[$];
  bcd_score_counter_if #(.DIGITS(DIGITS)) bus ();
  bcd_score_counter #(.DIGITS(DIGITS), .COMBO_LEN(CLEN)) dut (
    .CLOCK(clk),
    .RESET(rst),
    .bus  (bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic int to_bcd(input int v);
    int r = 0;
    for (int i = 0; i < DIGITS; i++) begin
      r = r | ((v % 10) << (4 * i));
      v = v / 10;
    end
    return r;
  endfunction
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input bit r, input bit c, input bit u1, input bit u2, input bit d2, input bit d1);
    exp_t e;
    int   d, s;
    bit   cmb;
    rst = r; bus.CLEAR = c; bus.UP1 = u1; bus.UP2 = u2; bus.DOWN2 = d2; bus.DOWN1 = d1;
    e.ov = 0; e.un = 0;
`ifdef BCD_SCORE_COMBO_EN
    cmb = m_streak >= CLEN;
`else
    cmb = 0;
`endif
    if (r || c) begin
      m_score = 0; m_streak = 0;
    end else if (u1 || u2) begin
      d = (u2 ? 2 : 1) * (cmb ? 2 : 1);
      s = m_score + d;
      if (s > MAXV) begin m_score = MAXV; e.ov = 1; end else m_score = s;
      m_streak = m_streak < 15 ? m_streak + 1 : 15;
    end else if (d2 || d1) begin
      s = m_score - (d2 ? 2 : 1);
      if (s < 0) begin m_score = 0; e.un = 1; end else m_score = s;
      m_streak = 0;
    end
    e.score = m_score;
    e.zero  = m_score == 0;
`ifdef BCD_SCORE_COMBO_EN
    e.combo = m_streak >= CLEN;
`else
    e.combo = 0;
`endif
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("score", int'(bus.SCORE), to_bcd(e.score));
    chk("zero", int'(bus.ZERO), int'(e.zero));
    chk("overflow", int'(bus.OVERFLOW), int'(e.ov));
    chk("underflow", int'(bus.UNDERFLOW), int'(e.un));
    chk("combo", int'(bus.COMBO), int'(e.combo));
  endtask
  task automatic rep(input int n, input bit u1, input bit u2);
    for (int i = 0; i < n; i++) step(0, 0, u1, u2, 0, 0);
  endtask
  initial begin
    checks = 0; failures = 0; m_score = 0; m_streak = 0;
    rst = 1; bus.CLEAR = 0; bus.UP1 = 0; bus.UP2 = 0; bus.DOWN2 = 0; bus.DOWN1 = 0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0);
    rep(228, 0, 1);
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    rep(49, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    rep(449, 0, 1);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    rep(25, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 1, 0, 0);
    rep(5, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    rep(3, 0, 1);
    step(0, 1, 0, 0, 0, 0);
    rep(3, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
